// File: rtl/ad7946_decimator.sv
// ad7946_decimator: two-channel boxcar averager (2^LOG2_DEC samples) feeding a 4-entry valid/ready FIFO.
// Define DECIM_ROUND_EN for round-half-up averages; default build truncates.
module ad7946_decimator #(
  parameter int LOG2_DEC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ch0_dv,
  input  logic        ch1_dv,
  input  logic [13:0] din,
  input  logic        clear,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_chan,
  output logic [13:0] m_data,
  output logic        ovf,
  output logic        err
);
  localparam int AW = 14 + LOG2_DEC;
  localparam int CW = LOG2_DEC > 0 ? LOG2_DEC : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_DEC) - 1);
`ifdef DECIM_ROUND_EN
  localparam logic [AW-1:0] RND = AW'((1 << LOG2_DEC) >> 1);
`else
  localparam logic [AW-1:0] RND = '0;
`endif
  logic [AW-1:0] acc_q [2];
  logic [AW-1:0] acc_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [14:0]   mem_q [4];
  logic [2:0]    wr_q, wr_d, rd_q, rd_d;
  logic          ovf_q, ovf_d, err_q, err_d;
  logic          sel, one, last, push, push_ok, pop, full, empty;
  logic [AW-1:0] sum;
  logic [13:0]   res;
  // sum + RND cannot overflow AW bits: 16383*2^L + 2^(L-1) < 2^(14+L)
  always_comb begin
    sel     = ch1_dv;
    one     = ch0_dv ^ ch1_dv;
    sum     = acc_q[sel] + AW'(din);
    last    = cnt_q[sel] == CNT_LAST;
    res     = 14'((sum + RND) >> LOG2_DEC);
    push    = one && last;
    empty   = wr_q == rd_q;
    full    = wr_q == {~rd_q[2], rd_q[1:0]};
    pop     = !empty && m_ready;
    push_ok = push && (!full || pop);
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (one) begin
      acc_d[sel] = last ? '0 : sum;
      cnt_d[sel] = last ? '0 : cnt_q[sel] + CW'(1);
    end
    wr_d  = wr_q + 3'(push_ok);
    rd_d  = rd_q + 3'(pop);
    ovf_d = ovf_q | (push && full && !pop);
    err_d = err_q | (ch0_dv && ch1_dv);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '{default: '0};
      cnt_q <= '{default: '0};
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else if (clear) begin
      acc_q <= '{default: '0};
      cnt_q <= '{default: '0};
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
      if (push_ok) mem_q[wr_q[1:0]] <= {sel, res};
    end
  end
  assign m_valid          = !empty;
  assign {m_chan, m_data} = mem_q[rd_q[1:0]];
  assign ovf              = ovf_q;
  assign err              = err_q;
endmodule

// File: doc/ad7946_decimator.md
# ad7946_decimator

Two-channel boxcar decimator that sits directly downstream of the AD7946 controller. It consumes the controller's per-channel sample strobes (`ch0_dv`, `ch1_dv`) and the shared 14-bit `dout` bus. It averages 2^LOG2_DEC samples per channel and pushes the channel-tagged averages into a 4-entry output FIFO with a valid/ready interface. The output feeds the capture/ILA or a host stream, so full-rate 500 kSPS traffic is reduced before leaving the ADC clock domain logic.

## Interface
- `LOG2_DEC`, 4, log2 of decimation ratio per channel; legal range 0..8.
- `clk` in 1: system clock (100 MHz clock-wizard output); all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset; deassertion synchronised externally.
- `ch0_dv` in 1: one-cycle strobe, `din` holds a channel-0 sample.
- `ch1_dv` in 1: one-cycle strobe, `din` holds a channel-1 sample.
- `din` in 14: unsigned straight-binary ADC code from controller `dout`.
- `clear` in 1: synchronous; zeroes accumulators, counters, FIFO, and sticky flags.
- `m_valid` out 1: FIFO head valid.
- `m_ready` in 1: consumer accepts head when `m_valid && m_ready`.
- `m_chan` out 1: channel of head entry (0/1).
- `m_data` out 14: averaged code of head entry.
- `ovf` out 1: sticky; a result was dropped because the FIFO was full.
- `err` out 1: sticky; `ch0_dv` and `ch1_dv` were asserted in the same cycle.

## Operation
- Per channel: accumulator `acc_c` (width 14+LOG2_DEC) and sample counter `cnt_c` (LOG2_DEC bits).
- On `chX_dv` (not both):
  - If `cnt_c != 2^LOG2_DEC-1`: `acc_c += din`, `cnt_c += 1`.
  - Else: `sum = acc_c + din`; `result = sum >> LOG2_DEC` (rounding per Configuration); push {c, result}; `acc_c <= 0`, `cnt_c <= 0`.
- LOG2_DEC=0: every strobe pushes `din` unchanged.
- Both strobes high in one cycle: both samples discarded, no state change in accumulators/counters, `err <= 1`.
- FIFO: 4 entries, circular pointers with wrap bit.
  - Push when full and no pop in the same cycle: entry dropped, `ovf <= 1`, accumulator still cleared.
  - Push and pop in the same cycle when full: both succeed, occupancy stays 4.
  - Push and pop in the same cycle when empty: no bypass. The push lands and `m_valid` rises next cycle.
- `m_chan`/`m_data` are held stable while `m_valid && !m_ready`.
- `clear` has priority over strobes and handshake in the same cycle. Any sample strobed in that cycle is discarded.
- Reset mid-accumulation: partial sums are lost; first post-reset result covers a full 2^LOG2_DEC fresh samples.

## Timing
- Reset values: `m_valid`=0, `m_chan`=0, `m_data`=0, `ovf`=0, `err`=0, all accumulators/counters/pointers 0.
- Latency: the final strobe of a block at edge N writes the FIFO. `m_valid` is high after edge N (visible in cycle N+1) when the FIFO was empty.
- Sticky flags set on the edge following the offending cycle; cleared only by `clear` or `rst_n`.
- `m_data`/`m_chan` are registered FIFO-head outputs; no combinational path from `din` or `m_ready`.
- Sustained input: one strobe per cycle on alternating channels must be accepted without loss. Only FIFO backpressure drops data.

## Configuration
- `DECIM_ROUND_EN` defined: `result = (sum + 2^(LOG2_DEC-1)) >> LOG2_DEC` (round half up; for LOG2_DEC=0 add 0).
  - Maximum is 16383, so no saturation is needed.
- Not defined: `result = sum >> LOG2_DEC` (truncate).

## Test plan
- Round result: LOG2_DEC=2, `m_ready`=1; ch0 samples 1,2,2,2 (sum 7).
  - `DECIM_ROUND_EN`: `m_chan`=0, `m_data`=2.
  - Without the macro: `m_data`=1.
  - Exactly one `m_valid` pulse, one cycle after the fourth strobe.
- Interleaving: LOG2_DEC=2, alternating ch0=16383 and ch1=0 strobes every cycle for 8 cycles. Required outputs, in that order:
  - {0,16383}
  - {1,0}
  - No `ovf`.
- Backpressure: LOG2_DEC=0, `m_ready`=0, six ch1 strobes with din 10..15.
  - FIFO holds 10,11,12,13.
  - `ovf`=1.
  - After `m_ready`=1, outputs are exactly 10,11,12,13.
- Full plus same-cycle pop: FIFO full, `m_ready`=1 while a push arrives. The push is accepted, `ovf` stays 0, and order is preserved.
- Collision: assert `ch0_dv`=`ch1_dv`=1 with din=100.
  - `err`=1; counters unchanged.
  - The next four ch0 samples of 4 yield `m_data`=4.
- Reset/clear mid-block: after 2 of 4 samples, pulse `rst_n`=0 (async, mid-cycle). Outputs go to reset values immediately; the next full block of 8s yields 8. Repeat the same check with `clear`.
